// File: rtl/dec24_strobe_gen.sv
// Purpose: decode an (x,y,v) priority-encoder request into a timed one-hot strobe, then a one-cycle done gap.
// Latency: request accepted at edge k drives d_out for HOLD cycles from k+1; done in the following cycle.
// Backpressure: in_ready is high only in IDLE; inputs are ignored while a request is in progress.
module dec24_strobe_gen #(
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             y,
    input  logic             v,
    output logic             in_ready,
    output logic [3:0]       d_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] req_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Hold counter is 8 bits wide because HOLD is limited to 1..255.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [1:0] code, code_nxt;
    logic [3:0] d_nxt;
    logic       accept;

    function automatic logic [3:0] decode(input logic [1:0] idx);
        decode = 4'b0001 << idx;
    endfunction

    // Readiness depends on state only, never on x/y/v.
    assign in_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, hold counter, latched code and next decoded line.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        code_nxt  = code;
        d_nxt     = d_out;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                d_nxt = 4'b0000;
                if (v) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                    hold_nxt  = HOLD_LOAD;
                    code_nxt  = {x, y};
                    d_nxt     = decode({x, y});
                end
            end
            DRIVE: begin
                if (hold_cnt == 8'd0) begin
                    state_nxt = GAP;
                    d_nxt     = 4'b0000;
                end else begin
                    hold_nxt = hold_cnt - 8'd1;
                    d_nxt    = decode(code);
                end
            end
            GAP: begin
                state_nxt = IDLE;
                d_nxt     = 4'b0000;
            end
            default: begin
                state_nxt = IDLE;
                d_nxt     = 4'b0000;
            end
        endcase
    end

    // Datapath and registered outputs; busy/done are flopped from the next state so they line up with d_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
            code     <= 2'b00;
            d_out    <= 4'b0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            req_cnt  <= '0;
        end else begin
            hold_cnt <= hold_nxt;
            code     <= code_nxt;
            d_out    <= d_nxt;
            busy     <= (state_nxt == DRIVE) || (state_nxt == GAP);
            done     <= (state_nxt == GAP);
            if (accept) begin
                req_cnt <= req_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dec24_strobe_gen.sv
module tb_dec24_strobe_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       xa, ya, va, xb, yb, vb;
    logic       rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
    logic [3:0] d_a, d_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int tests = 0;
    int fails = 0;
    int done_seen_a = 0;

    always #5 clk = ~clk;

    dec24_strobe_gen #(.HOLD(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .x(xa), .y(ya), .v(va),
        .in_ready(rdy_a), .d_out(d_a), .busy(busy_a), .done(done_a), .req_cnt(cnt_a)
    );

    dec24_strobe_gen #(.HOLD(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x(xb), .y(yb), .v(vb),
        .in_ready(rdy_b), .d_out(d_b), .busy(busy_b), .done(done_b), .req_cnt(cnt_b)
    );

    // Reference model: each request occupies HOLD+1 cycles after its accept edge
    // (HOLD strobe cycles, then one gap cycle). "left" counts those cycles down.
    int         left [2];
    logic [1:0] mcode [2];
    int         mcnt [2];

    function automatic int hold_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic int cmod_of(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    function automatic logic [3:0] exp_d(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return (left[i] >= 2) ? (one << mcode[i]) : 4'b0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                left[i]  <= 0;
                mcode[i] <= 2'b00;
                mcnt[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic       vi;
                logic [1:0] ci;
                vi = (i == 0) ? va : vb;
                ci = (i == 0) ? {xa, ya} : {xb, yb};
                if (left[i] == 0) begin
                    if (vi) begin
                        left[i]  <= hold_of(i) + 1;
                        mcode[i] <= ci;
                        mcnt[i]  <= mcnt[i] + 1;
                    end
                end else begin
                    left[i] <= left[i] - 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("a_d_out", 32'(d_a), 32'(exp_d(0)));
        check("a_done", 32'(done_a), 32'(left[0] == 1));
        check("a_busy", 32'(busy_a), 32'(left[0] != 0));
        check("a_in_ready", 32'(rdy_a), 32'(left[0] == 0));
        check("a_req_cnt", 32'(cnt_a), 32'(mcnt[0] % cmod_of(0)));
        check("b_d_out", 32'(d_b), 32'(exp_d(1)));
        check("b_done", 32'(done_b), 32'(left[1] == 1));
        check("b_busy", 32'(busy_b), 32'(left[1] != 0));
        check("b_in_ready", 32'(rdy_b), 32'(left[1] == 0));
        check("b_req_cnt", 32'(cnt_b), 32'(mcnt[1] % cmod_of(1)));
        if (done_a === 1'b1) done_seen_a++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a;
        int n;
        n = 0;
        while (rdy_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("a_idle_timeout", 32'(rdy_a), 32'd1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    int         d0;
    logic [1:0] sc;
    logic [1:0] wrap_exp [5];

    initial begin
        rst = 1'b0; va = 0; xa = 0; ya = 0; vb = 0; xb = 0; yb = 0;
        #1 rst = 1'b1;

        // Reset then idle
        tick(); tick();
        #3;
        check("rst_d_out", 32'(d_a), 32'h0);
        check("rst_in_ready", 32'(rdy_a), 32'h1);
        check("rst_req_cnt", 32'(cnt_a), 32'h0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        #3;
        check("idle_busy", 32'(busy_a), 32'h0);
        check("idle_done", 32'(done_a), 32'h0);
        check("idle_in_ready", 32'(rdy_a), 32'h1);

        // Single request XY=10
        va = 1; xa = 1; ya = 0;
        tick();
        va = 0; xa = 0;
        check("pin_model_drive", 32'(exp_d(0)), 32'h4);
        for (int i = 0; i < 3; i++) begin
            #3;
            check("single_d_out", 32'(d_a), 32'h4);
            check("single_in_ready_low", 32'(rdy_a), 32'h0);
            tick();
        end
        #3;
        check("single_gap_d", 32'(d_a), 32'h0);
        check("single_gap_done", 32'(done_a), 32'h1);
        check("pin_model_gap", 32'(left[0]), 32'd1);
        tick();
        #3;
        check("single_ready", 32'(rdy_a), 32'h1);
        check("single_req_cnt", 32'(cnt_a), 32'd1);

        // Sweep of all four codes, v held high, period HOLD+2
        do_reset();
        d0 = done_seen_a;
        va = 1;
        for (int c = 0; c < 4; c++) begin
            sc = 2'(c);
            xa = sc[1]; ya = sc[0];
            tick();
            #3;
            check("sweep_d_out", 32'(d_a), 32'(4'b0001 << c));
            repeat (4) tick();
            check("sweep_ready_again", 32'(rdy_a), 32'h1);
        end
        va = 0;
        tick();
        check("sweep_done_count", 32'(done_seen_a - d0), 32'd4);
        check("sweep_req_cnt", 32'(cnt_a), 32'd4);

        // Input change while busy
        wait_idle_a();
        va = 1; xa = 1; ya = 1;
        tick();
        xa = 0; ya = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("busy_hold_d_out", 32'(d_a), 32'h8);
            tick();
        end
        tick();
        tick();
        va = 0;
        #3;
        check("busy_next_code", 32'(d_a), 32'h1);
        wait_idle_a();

        // Reset mid-DRIVE
        va = 1; xa = 0; ya = 1;
        tick();
        va = 0;
        tick();
        #2;
        d0 = done_seen_a;
        rst = 1'b1;
        #1;
        check("midrst_d_out", 32'(d_a), 32'h0);
        check("midrst_busy", 32'(busy_a), 32'h0);
        check("midrst_req_cnt", 32'(cnt_a), 32'h0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("midrst_no_done", 32'(done_seen_a - d0), 32'd0);

        // HOLD=1 instance: counter wrap with back-to-back requests
        do_reset();
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        vb = 1;
        for (int n = 0; n < 5; n++) begin
            xb = 1'($urandom_range(0, 1));
            yb = 1'($urandom_range(0, 1));
            tick();
            #3;
            check("wrap_req_cnt", 32'(cnt_b), 32'(wrap_exp[n]));
            check("wrap_d_active", 32'(d_b != 4'b0000), 32'h1);
            tick();
            #3;
            check("wrap_gap_done", 32'(done_b), 32'h1);
            tick();
            #3;
            check("wrap_ready", 32'(rdy_b), 32'h1);
        end
        vb = 0;
        tick();

        // Randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 600; n++) begin
            va = 1'($urandom_range(0, 1)); xa = 1'($urandom_range(0, 1)); ya = 1'($urandom_range(0, 1));
            vb = 1'($urandom_range(0, 1)); xb = 1'($urandom_range(0, 1)); yb = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; va = 0; vb = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
